seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

- Receive-side counterpart to the AutoRotate 7-segment display driver.
- Monitors the multiplexed anode and segment lines and reconstructs the four displayed hex characters.
- Flags malformed scans and signals each complete, changed frame, so a bench or on-chip checker can verify the rotating message without reading waveforms.
- Sits directly on the driver's output pins, in the same clock domain.

## Interface

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before a digit is committed (range 2..15).

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-low reset.
- an3, an2, an1, an0  in  1 each  digit anodes, active-low; anN low selects digit N.
- a, b, c, d, e, f, g  in  1 each  segment cathodes, active-low (0 = lit).
- dp  in  1  decimal point, active-low.
- char3, char2, char1, char0  out  4 each  last committed hex code per digit.
- digit_valid  out  4  bit N set when charN holds a legally decoded glyph.
- dp_flags  out  4  bit N = dp was lit at digit N's last commit.
- frame_strobe  out  1  one-cycle pulse at each complete frame.
- frame_changed  out  1  one-cycle pulse, coincident with frame_strobe, when the frame content differs from the previous strobed frame.
- bad_glyph  out  1  one-cycle pulse when a committed pattern matches no glyph.
- multi_an  out  1  one-cycle pulse when a stable sample has more than one anode low.

## Operation

**Input synchronization**
- All 12 inputs pass through a 2-flop synchronizer.
- Synchronizer idle/reset value is all ones (blank display).

**Stability counter**
- Counts consecutive cycles in which the synchronized sample {an3..an0, a..g, dp} equals the previous sample.
- Resets to 0 on any change.
- Saturates at STABLE_CYCLES-1.

**Commit**
- One commit per dwell, on the cycle the counter first reaches STABLE_CYCLES-1.
- Exactly one anode low (digit N):
  - Decode {a..g} as below.
  - Valid glyph: charN <= code, digit_valid[N] <= 1, dp_flags[N] <= ~dp.
  - No match: digit_valid[N] <= 0, charN held, bad_glyph pulse.
- All anodes high: blank, no action.
- Two or more anodes low: multi_an pulse; nothing written.

**Glyph table** (lit segments → code; any other pattern is illegal):
- 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
- 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg

**Frame**
- A commit to digit 0 with digit_valid == 4'b1111 (after update) produces frame_strobe.
- frame_changed pulses with it if {char3..char0} differs from the snapshot taken at the previous strobe.
- The snapshot is updated at every strobe.
- The first strobe after reset always asserts frame_changed.

**Reset** (asynchronous, any time):
- All outputs 0.
- Counter 0, snapshot 0, snapshot-valid flag cleared, synchronizers all ones.
- A dwell in progress is discarded.

## Timing

- Input change at edge E → first synchronized sample at E+2.
- Commit (registered outputs update) at edge E+2+STABLE_CYCLES-1 if the inputs hold.
- With default 4: new char visible 5 edges after the inputs settle.
- Pulses (frame_strobe, frame_changed, bad_glyph, multi_an) are high for exactly one cycle, registered, aligned with the commit edge.
- A dwell shorter than STABLE_CYCLES samples never commits; ghost/transition patterns between anode switches are thereby rejected.
- A dwell that lasts indefinitely commits once only; re-commit requires a sample change.
- bad_glyph and multi_an never occur on the same cycle (mutually exclusive conditions).
- Hold from reset release: first commit is no earlier than edge 2+STABLE_CYCLES-1 after release.

## Test plan

- Reset low mid-dwell with an0=0, segments="8" → all outputs 0; after release, dwell held 10 cycles → char0=8, digit_valid=0001, no frame_strobe.
- Scan "1","2","3","4" on an3..an0, 20 cycles each → chars 1,2,3,4, digit_valid=1111, frame_strobe + frame_changed at the an0 commit.
- Repeat the identical scan → frame_strobe pulses each frame, frame_changed stays 0.
- Rotate the message to "2","3","4","1" → frame_changed pulses once, chars 2,3,4,1.
- Hold an1=0 with segments abg (illegal) → bad_glyph one pulse, digit_valid[1]=0, char1 unchanged.
- an2=an1=0 for 10 cycles → one multi_an pulse, no char change. Then a 2-cycle glitch pattern on an0 → no commit, no pulses.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a multiplexed 7-segment display: synchronizes the
// pins, waits for each digit dwell to settle, decodes the glyph and reports frames.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       an3,
  input  logic       an2,
  input  logic       an1,
  input  logic       an0,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic [3:0] digit_valid,
  output logic [3:0] dp_flags,
  output logic       frame_strobe,
  output logic       frame_changed,
  output logic       bad_glyph,
  output logic       multi_an
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_PRE = 4'(STABLE_CYCLES - 2);

  logic [11:0]      pins;
  logic [11:0]      sync1_q, sync2_q;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0][3:0]  chars_q, chars_d;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       dpf_q, dpf_d;
  logic [15:0]      snap_q, snap_d;
  logic             snap_vld_q, snap_vld_d;
  logic             strobe_q, strobe_d;
  logic             chg_q, chg_d;
  logic             bad_q, bad_d;
  logic             multi_q, multi_d;

  logic             stable;
  logic             commit;
  logic [3:0]       an_low;
  logic [6:0]       lit;
  logic             one_hot;
  logic             many;
  logic [1:0]       idx;
  logic             glyph_ok;
  logic [3:0]       code;

  assign pins = {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      cnt_q      <= '0;
      chars_q    <= '0;
      valid_q    <= '0;
      dpf_q      <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      strobe_q   <= 1'b0;
      chg_q      <= 1'b0;
      bad_q      <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      sync1_q    <= pins;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      chars_q    <= chars_d;
      valid_q    <= valid_d;
      dpf_q      <= dpf_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      strobe_q   <= strobe_d;
      chg_q      <= chg_d;
      bad_q      <= bad_d;
      multi_q    <= multi_d;
    end
  end

  // sync1_q is the sample about to land in sync2_q, so comparing the two lets
  // the commit coincide with the counter reaching its saturation value.
  always_comb begin
    stable = (sync1_q == sync2_q);
    cnt_d  = '0;
    if (stable) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
    commit = stable && (cnt_q == CNT_PRE);
  end

  always_comb begin
    an_low  = ~sync2_q[11:8];
    lit     = ~sync2_q[7:1];
    one_hot = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
    many    = (an_low != 4'd0) && !one_hot;
    idx     = 2'd0;
    case (an_low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // lit pattern ordered {a,b,c,d,e,f,g}
  always_comb begin
    glyph_ok = 1'b1;
    code     = 4'h0;
    case (lit)
      7'h7E: code = 4'h0;
      7'h30: code = 4'h1;
      7'h6D: code = 4'h2;
      7'h79: code = 4'h3;
      7'h33: code = 4'h4;
      7'h5B: code = 4'h5;
      7'h5F: code = 4'h6;
      7'h70: code = 4'h7;
      7'h7F: code = 4'h8;
      7'h7B: code = 4'h9;
      7'h77: code = 4'hA;
      7'h1F: code = 4'hB;
      7'h4E: code = 4'hC;
      7'h3D: code = 4'hD;
      7'h4F: code = 4'hE;
      7'h47: code = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    chars_d    = chars_q;
    valid_d    = valid_q;
    dpf_d      = dpf_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    strobe_d   = 1'b0;
    chg_d      = 1'b0;
    bad_d      = 1'b0;
    multi_d    = 1'b0;
    if (commit) begin
      if (many) begin
        multi_d = 1'b1;
      end else if (one_hot) begin
        if (glyph_ok) begin
          chars_d[idx] = code;
          valid_d[idx] = 1'b1;
          dpf_d[idx]   = ~sync2_q[0];
          if (idx == 2'd0 && valid_d == 4'hF) begin
            strobe_d   = 1'b1;
            chg_d      = !snap_vld_q || (chars_d != snap_q);
            snap_d     = chars_d;
            snap_vld_d = 1'b1;
          end
        end else begin
          valid_d[idx] = 1'b0;
          bad_d        = 1'b1;
        end
      end
    end
  end

  assign char3         = chars_q[3];
  assign char2         = chars_q[2];
  assign char1         = chars_q[1];
  assign char0         = chars_q[0];
  assign digit_valid   = valid_q;
  assign dp_flags      = dpf_q;
  assign frame_strobe  = strobe_q;
  assign frame_changed = chg_q;
  assign bad_glyph     = bad_q;
  assign multi_an      = multi_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scan table, reset/timing sequence and
// randomized dwells checked against a dwell-level reference model.
module tb_seven_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] drv = 12'hFFF;
  logic [3:0]  char3, char2, char1, char0, digit_valid, dp_flags;
  logic        frame_strobe, frame_changed, bad_glyph, multi_an;

  seven_seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .an3(drv[11]), .an2(drv[10]), .an1(drv[9]), .an0(drv[8]),
    .a(drv[7]), .b(drv[6]), .c(drv[5]), .d(drv[4]), .e(drv[3]), .f(drv[2]), .g(drv[1]),
    .dp(drv[0]),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .digit_valid(digit_valid), .dp_flags(dp_flags),
    .frame_strobe(frame_strobe), .frame_changed(frame_changed),
    .bad_glyph(bad_glyph), .multi_an(multi_an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mon_strobe = 0, mon_chg = 0, mon_bad = 0, mon_multi = 0, mon_excl = 0;

  // lit segments {a..g} for hex 0..F
  logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always @(negedge clk) begin
    if (reset) begin
      if (frame_strobe) mon_strobe++;
      if (frame_changed) mon_chg++;
      if (bad_glyph) mon_bad++;
      if (multi_an) mon_multi++;
      if (bad_glyph && multi_an) mon_excl++;
      if (frame_changed && !frame_strobe) mon_excl++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mkpat(input logic [3:0] an_drv, input logic [6:0] lit,
                                        input logic dpl);
    return {an_drv, ~lit, ~dpl};
  endfunction

  task automatic hold(input logic [11:0] p, input int n);
    drv = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] chars_now();
    return {char3, char2, char1, char0};
  endfunction

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  lit;
    logic        dpl;
    int          len;
    logic [15:0] chars;
    logic [3:0]  valid;
    logic [3:0]  dpf;
    int          strobe, chg, bad, multi;
  } vec_t;

  vec_t tbl [16];

  // dwell-level reference model
  logic [3:0]  mc [4];
  logic [3:0]  mv, md;
  logic [15:0] msnap;
  logic        msnap_vld;
  int          es, ec, eb, em;
  logic [11:0] cur_pat;
  int          cur_len;

  task automatic model_commit(input logic [11:0] p);
    logic [3:0] anl;
    logic [6:0] lt;
    int n, dg, cd;
    logic [15:0] fr;
    anl = ~p[11:8];
    lt  = ~p[7:1];
    n   = $countones(anl);
    if (n >= 2) begin
      em++;
    end else if (n == 1) begin
      dg = 0;
      for (int i = 0; i < 4; i++) if (anl[i]) dg = i;
      cd = -1;
      for (int i = 0; i < 16; i++) if (lut[i] == lt) cd = i;
      if (cd >= 0) begin
        mc[dg] = 4'(cd);
        mv[dg] = 1'b1;
        md[dg] = ~p[0];
        if (dg == 0 && mv == 4'hF) begin
          es++;
          fr = {mc[3], mc[2], mc[1], mc[0]};
          if (!msnap_vld || fr != msnap) ec++;
          msnap = fr;
          msnap_vld = 1'b1;
        end
      end else begin
        mv[dg] = 1'b0;
        eb++;
      end
    end
  endtask

  task automatic model_dwell(input logic [11:0] p, input int len);
    if (p == cur_pat) begin
      cur_len += len;
    end else begin
      if (cur_len >= S) model_commit(cur_pat);
      cur_pat = p;
      cur_len = len;
    end
    hold(p, len);
  endtask

  function automatic vec_t mk(input logic [3:0] an, input logic [6:0] lit, input logic dpl,
                              input int len, input logic [15:0] ch, input logic [3:0] v,
                              input logic [3:0] dpf, input int st, input int cg,
                              input int bd, input int mu);
    vec_t r;
    r.an = an; r.lit = lit; r.dpl = dpl; r.len = len; r.chars = ch; r.valid = v;
    r.dpf = dpf; r.strobe = st; r.chg = cg; r.bad = bd; r.multi = mu;
    return r;
  endfunction

  initial begin
    int b_s, b_c, b_b, b_m;
    logic [3:0]  ran;
    logic [6:0]  rlit;
    int r;

    tbl[0]  = mk(4'b0111, lut[1], 1'b0, 20, 16'h1008, 4'b1001, 4'b0000, 0, 0, 0, 0);
    tbl[1]  = mk(4'b1011, lut[2], 1'b1, 20, 16'h1208, 4'b1101, 4'b0100, 0, 0, 0, 0);
    tbl[2]  = mk(4'b1101, lut[3], 1'b0, 20, 16'h1238, 4'b1111, 4'b0100, 0, 0, 0, 0);
    tbl[3]  = mk(4'b1110, lut[4], 1'b0, 20, 16'h1234, 4'b1111, 4'b0100, 1, 1, 0, 0);
    tbl[4]  = mk(4'b0111, lut[1], 1'b0, 20, 16'h1234, 4'b1111, 4'b0100, 0, 0, 0, 0);
    tbl[5]  = mk(4'b1011, lut[2], 1'b1, 20, 16'h1234, 4'b1111, 4'b0100, 0, 0, 0, 0);
    tbl[6]  = mk(4'b1101, lut[3], 1'b0, 20, 16'h1234, 4'b1111, 4'b0100, 0, 0, 0, 0);
    tbl[7]  = mk(4'b1110, lut[4], 1'b0, 20, 16'h1234, 4'b1111, 4'b0100, 1, 0, 0, 0);
    tbl[8]  = mk(4'b0111, lut[2], 1'b0, 20, 16'h2234, 4'b1111, 4'b0100, 0, 0, 0, 0);
    tbl[9]  = mk(4'b1011, lut[3], 1'b0, 20, 16'h2334, 4'b1111, 4'b0000, 0, 0, 0, 0);
    tbl[10] = mk(4'b1101, lut[4], 1'b0, 20, 16'h2344, 4'b1111, 4'b0000, 0, 0, 0, 0);
    tbl[11] = mk(4'b1110, lut[1], 1'b0, 20, 16'h2341, 4'b1111, 4'b0000, 1, 1, 0, 0);
    tbl[12] = mk(4'b1101, 7'h61,  1'b0, 20, 16'h2341, 4'b1101, 4'b0000, 0, 0, 1, 0);
    tbl[13] = mk(4'b1001, lut[8], 1'b0, 10, 16'h2341, 4'b1101, 4'b0000, 0, 0, 0, 1);
    tbl[14] = mk(4'b1110, lut[8], 1'b0, 2,  16'h2341, 4'b1101, 4'b0000, 0, 0, 0, 0);
    tbl[15] = mk(4'b1111, 7'h00,  1'b0, 10, 16'h2341, 4'b1101, 4'b0000, 0, 0, 0, 0);

    // reset, then an async reset in the middle of a committed "8" dwell on digit 0
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {chars_now(), digit_valid, dp_flags, frame_strobe, frame_changed,
                            bad_glyph, multi_an}, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    hold(mkpat(4'b1110, lut[8], 1'b0), 8);
    check("pre_reset_char0", char0, 4'h8);
    #3 reset = 1'b0;
    #1;
    check("async_reset_outputs", {chars_now(), digit_valid, dp_flags, frame_strobe,
                                  frame_changed, bad_glyph, multi_an}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (S) @(posedge clk);
    #1;
    check("no_early_commit", {char0, digit_valid}, 0);
    @(posedge clk); #1;
    check("commit_edge_char0", char0, 4'h8);
    check("commit_edge_valid", digit_valid, 4'b0001);
    repeat (5) @(posedge clk);
    #1;
    check("single_digit_no_strobe", mon_strobe, 0);

    for (int i = 0; i < 16; i++) begin
      b_s = mon_strobe; b_c = mon_chg; b_b = mon_bad; b_m = mon_multi;
      hold(mkpat(tbl[i].an, tbl[i].lit, tbl[i].dpl), tbl[i].len);
      check($sformatf("tbl%0d_chars", i), chars_now(), tbl[i].chars);
      check($sformatf("tbl%0d_valid", i), digit_valid, tbl[i].valid);
      check($sformatf("tbl%0d_dp", i), dp_flags, tbl[i].dpf);
      check($sformatf("tbl%0d_strobe", i), mon_strobe - b_s, tbl[i].strobe);
      check($sformatf("tbl%0d_changed", i), mon_chg - b_c, tbl[i].chg);
      check($sformatf("tbl%0d_bad", i), mon_bad - b_b, tbl[i].bad);
      check($sformatf("tbl%0d_multi", i), mon_multi - b_m, tbl[i].multi);
    end

    mc[3] = 4'h2; mc[2] = 4'h3; mc[1] = 4'h4; mc[0] = 4'h1;
    mv = 4'b1101; md = 4'b0000; msnap = 16'h2341; msnap_vld = 1'b1;
    es = 0; ec = 0; eb = 0; em = 0;
    cur_pat = 12'hFFF; cur_len = 100;
    b_s = mon_strobe; b_c = mon_chg; b_b = mon_bad; b_m = mon_multi;

    for (int grp = 0; grp < 30; grp++) begin
      for (int k = 0; k < 8; k++) begin
        r = $urandom_range(0, 9);
        if (r <= 6) ran = ~(4'b0001 << $urandom_range(0, 3));
        else if (r == 7) ran = 4'b1111;
        else ran = ~(4'b0011 << $urandom_range(0, 2));
        rlit = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : lut[$urandom_range(0, 15)];
        model_dwell(mkpat(ran, rlit, 1'($urandom_range(0, 1))), $urandom_range(1, 8));
      end
      model_dwell(12'hFFF, 8);
      check($sformatf("rnd%0d_chars", grp), chars_now(), {mc[3], mc[2], mc[1], mc[0]});
      check($sformatf("rnd%0d_valid", grp), digit_valid, mv);
      check($sformatf("rnd%0d_dp", grp), dp_flags, md);
      check($sformatf("rnd%0d_strobes", grp), mon_strobe - b_s, es);
      check($sformatf("rnd%0d_changed", grp), mon_chg - b_c, ec);
      check($sformatf("rnd%0d_bad", grp), mon_bad - b_b, eb);
      check($sformatf("rnd%0d_multi", grp), mon_multi - b_m, em);
    end

    check("pulse_exclusivity", mon_excl, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
